sccb_target: RTL and testbench

- Synthesizable SCCB target (slave) that answers the camera-configuration master on the same SCL/SDA pair.
- Decodes 3-phase write cycles (device ID, sub-address, data) into an internal 256x8 register file.
- Used as a stand-in OV7670 register model for board bring-up and as a checker for the init sequence.
- Sits on the system clock. Drives SDA open-drain through an output-enable only.

---
 rtl/sccb_target_if.sv | 28 ++
 rtl/sccb_target.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_sccb_target.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_target_if.sv
// ---------------------------------------------------------------------------
// sccb_target_if
//   SCCB pad bundle between a configuration master and the sccb_target.
//   Signals:
//     scl    - SCCB clock as seen at the pad
//     sda_in - SDA as seen at the pad (wired-AND of all drivers)
//     sda_oe - target pull-down enable (1 = pull SDA low, 0 = release)
//   Modports:
//     master - bench/pad side: provides scl and the resolved sda_in
//     slave  - target side: observes scl/sda_in, drives sda_oe
// ---------------------------------------------------------------------------
interface sccb_target_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (
    output scl,
    output sda_in,
    input  sda_oe
  );

  modport slave (
    input  scl,
    input  sda_in,
    output sda_oe
  );
endinterface

// File: rtl/sccb_target.sv
// ---------------------------------------------------------------------------
// sccb_target
//   SCCB target (slave) that decodes 3-phase write cycles (device ID,
//   sub-address, data) into a 256x8 register file. Serves as a stand-in
//   camera register model and as a checker for an init sequence.
//   SDA is driven open-drain via bus.sda_oe only.
//
//   Optional build macro: SCCB_TARGET_READ_EN
//     defined   - DEV_ID|1 is acknowledged and the byte at the current
//                 sub-address pointer is shifted out (pointer not advanced)
//     undefined - DEV_ID|1 is not acknowledged; no read logic exists
//
//   Parameters:
//     DEV_ID      - 8-bit write ID (DEV_ID|1 is the read ID)
//     SYNC_STAGES - flops in the SCL/SDA input synchronizers (>= 2)
//
//   Ports:
//     clk      in   system clock
//     reset    in   asynchronous active-low reset
//     bus      if   scl / sda_in / sda_oe (slave modport)
//     wr_stb   out  one-clk pulse per accepted data byte
//     wr_addr  out  sub-address of the last write
//     wr_data  out  data of the last write
//     busy     out  high from START until STOP
//     wr_cnt   out  accepted writes, saturating at 255
//     dbg_addr in   register-file read address
//     dbg_data out  combinational register-file read data
// ---------------------------------------------------------------------------
module sccb_target #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  sccb_target_if.slave     bus,
  output logic             wr_stb,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic [7:0]       wr_cnt,
  input  logic [7:0]       dbg_addr,
  output logic [7:0]       dbg_data
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ID,
    S_ACK_ID,
    S_SUB_ADDR,
    S_ACK_SUB,
    S_WR_DATA,
    S_ACK_DATA,
    S_WAIT_STOP
`ifdef SCCB_TARGET_READ_EN
    , S_ACK_RID,
    S_RD_DATA,
    S_RD_NA
`endif
  } state_t;

  // ---------------- input conditioning ----------------
  // Synchronizers reset to 1 (idle bus level) so that reset release on an
  // idle bus cannot fabricate a START.
  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_hist_reg;
  logic                   sda_hist_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_hist_reg <= 1'b1;
      sda_hist_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], bus.scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], bus.sda_in};
      scl_hist_reg <= scl_sync_reg[SYNC_STAGES-1];
      sda_hist_reg <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_evt, stop_evt;

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_reg;
  assign scl_fall  = ~scl_s & scl_hist_reg;
  // START/STOP require SCL high both now and one clk ago, so an SDA change
  // that coincides with an SCL edge is never mistaken for a bus condition.
  assign start_evt = scl_s & scl_hist_reg & sda_hist_reg & ~sda_s;
  assign stop_evt  = scl_s & scl_hist_reg & ~sda_hist_reg & sda_s;

  // ---------------- state ----------------
  state_t     state_reg,   state_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shreg_reg,   shreg_next;
  logic [7:0] ptr_reg,     ptr_next;
  logic       sda_oe_reg,  sda_oe_next;
  logic       busy_reg,    busy_next;
  logic       wr_stb_reg,  wr_stb_next;
  logic [7:0] wr_addr_reg, wr_addr_next;
  logic [7:0] wr_data_reg, wr_data_next;
  logic [7:0] wr_cnt_reg,  wr_cnt_next;
  logic       mem_we;
  logic [7:0] shift_byte;

  logic [7:0] regs [256];

  // Byte as it stands once the bit on the current rising edge is included.
  assign shift_byte = {shreg_reg[6:0], sda_s};

`ifdef SCCB_TARGET_READ_EN
  logic [7:0] rd_byte;
  assign rd_byte = regs[ptr_reg];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
      ptr_reg     <= '0;
      sda_oe_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      wr_stb_reg  <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      ptr_reg     <= ptr_next;
      sda_oe_reg  <= sda_oe_next;
      busy_reg    <= busy_next;
      wr_stb_reg  <= wr_stb_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      wr_cnt_reg  <= wr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    ptr_next     = ptr_reg;
    sda_oe_next  = sda_oe_reg;
    busy_next    = busy_reg;
    wr_stb_next  = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    wr_cnt_next  = wr_cnt_reg;
    mem_we       = 1'b0;

    if (stop_evt) begin
      state_next  = S_IDLE;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
    end else if (start_evt) begin
      state_next   = S_DEV_ID;
      bit_cnt_next = '0;
      busy_next    = 1'b1;
      sda_oe_next  = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
        end

        S_DEV_ID: begin
          if (scl_rise && bit_cnt_reg != 4'd8) begin
            shreg_next   = shift_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            bit_cnt_next = '0;
            if (shreg_reg == DEV_ID) begin
              sda_oe_next = 1'b1;
              state_next  = S_ACK_ID;
`ifdef SCCB_TARGET_READ_EN
            end else if (shreg_reg == (DEV_ID | 8'h01)) begin
              sda_oe_next = 1'b1;
              state_next  = S_ACK_RID;
`endif
            end else begin
              sda_oe_next = 1'b0;
              state_next  = S_WAIT_STOP;
            end
          end
        end

        S_ACK_ID: begin
          if (scl_fall) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = '0;
            state_next   = S_SUB_ADDR;
          end
        end

        // Bits go straight into the pointer; a STOP after this phase
        // leaves the pointer set for a later read.
        S_SUB_ADDR: begin
          if (scl_rise && bit_cnt_reg != 4'd8) begin
            ptr_next     = {ptr_reg[6:0], sda_s};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            sda_oe_next = 1'b1;
            state_next  = S_ACK_SUB;
          end
        end

        S_ACK_SUB: begin
          if (scl_fall) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = '0;
            state_next   = S_WR_DATA;
          end
        end

        // The write commits on the rising edge of the last data bit,
        // ahead of the ACK clock.
        S_WR_DATA: begin
          if (scl_rise && bit_cnt_reg != 4'd8) begin
            shreg_next   = shift_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              mem_we       = 1'b1;
              wr_stb_next  = 1'b1;
              wr_addr_next = ptr_reg;
              wr_data_next = shift_byte;
              if (wr_cnt_reg != 8'hFF) begin
                wr_cnt_next = wr_cnt_reg + 8'd1;
              end
            end
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            sda_oe_next = 1'b1;
            state_next  = S_ACK_DATA;
          end
        end

        S_ACK_DATA: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
            state_next  = S_WAIT_STOP;
          end
        end

        S_WAIT_STOP: begin
          sda_oe_next = 1'b0;
        end

`ifdef SCCB_TARGET_READ_EN
        // The falling edge that ends the ID ACK already presents bit 7.
        S_ACK_RID: begin
          if (scl_fall) begin
            sda_oe_next  = ~rd_byte[7];
            bit_cnt_next = 4'd1;
            state_next   = S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg != 4'd8) begin
              sda_oe_next  = ~rd_byte[3'd7 - bit_cnt_reg[2:0]];
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end else begin
              sda_oe_next = 1'b0;
              state_next  = S_RD_NA;
            end
          end
        end

        // Master's NA/ACK bit is taken on this rising edge; either way the
        // transfer is over and only STOP/START can follow.
        S_RD_NA: begin
          if (scl_rise) begin
            state_next = S_WAIT_STOP;
          end
        end
`endif

        default: begin
          state_next  = S_IDLE;
          sda_oe_next = 1'b0;
        end
      endcase
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        regs[i] <= '0;
      end
    end else if (mem_we) begin
      regs[ptr_reg] <= shift_byte;
    end
  end

  assign dbg_data   = regs[dbg_addr];
  assign bus.sda_oe = sda_oe_reg;
  assign wr_stb     = wr_stb_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign busy       = busy_reg;
  assign wr_cnt     = wr_cnt_reg;

endmodule

// File: tb/tb_sccb_target.sv
// ---------------------------------------------------------------------------
// tb_sccb_target
//   Drives SCCB transactions into sccb_target through sccb_target_if.
//   Expected write strobes are queued when a transaction is issued; a
//   separate monitor pops and compares on every wr_stb pulse.
//   One SCL bit lasts 16 clk (4 quarter periods); with a 6.4 MHz system
//   clock that is a 400 kHz bus.
// ---------------------------------------------------------------------------
module tb_sccb_target;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       wr_stb;
  logic [7:0] wr_addr, wr_data, wr_cnt, dbg_data;
  logic       busy;
  logic [7:0] dbg_addr = 8'h00;

  always #5 clk = ~clk;

  sccb_target_if bus ();
  assign bus.scl    = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;   // open-drain wired-AND

  sccb_target #(.DEV_ID(8'h42), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .wr_cnt   (wr_cnt),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] cnt;
  } wr_exp_t;

  wr_exp_t    exp_q[$];
  logic [7:0] model [256];
  int         model_cnt = 0;

  task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
    model[a] = d;
    if (model_cnt < 255) model_cnt++;
    exp_q.push_back({a, d, 8'(model_cnt)});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    model_cnt = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    wr_exp_t e;
    if (reset && wr_stb) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr_stb actual addr=0x%0h data=0x%0h required=no strobe", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("stb_wr_addr", 32'(wr_addr), 32'(e.addr));
        check("stb_wr_data", 32'(wr_data), 32'(e.data));
        check("stb_wr_cnt",  32'(wr_cnt),  32'(e.cnt));
      end
    end
  end

  logic oe_watch = 1'b0;
  logic oe_seen  = 1'b0;
  always @(negedge clk) if (oe_watch && bus.sda_oe) oe_seen = 1'b1;

  // ---------------- bus primitives ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b0; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  // Releases SDA for one clock and returns the line level at mid-high.
  task automatic sample_bit(output logic v);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    @(negedge clk); v = bus.sda_in;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic v;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sample_bit(v);
    acked = ~v;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      sample_bit(v);
      d[i] = v;
    end
    send_bit(1'b1);   // NA
  endtask

  task automatic check_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  task automatic write3(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] data,
                        input logic exp_ack);
    logic a0, a1, a2;
    bus_start();
    check("busy_after_start", 32'(busy), 32'd1);
    send_byte(id, a0);
    send_byte(sub, a1);
    if (exp_ack) expect_write(sub, data);
    send_byte(data, a2);
    bus_stop();
    check("ack_id",   32'(a0), 32'(exp_ack));
    check("ack_sub",  32'(a1), 32'(exp_ack));
    check("ack_data", 32'(a2), 32'(exp_ack));
    check("busy_after_stop", 32'(busy), 32'd0);
    $display("WR id=%02h sub=%02h data=%02h acks=%b%b%b wr_cnt=%0d", id, sub, data, a0, a1, a2, wr_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       a;
    logic [7:0] d;
    logic [7:0] sa;

    model_reset();
    wait_clk(4);
    check("rst_sda_oe",  32'(bus.sda_oe), 32'd0);
    check("rst_busy",    32'(busy),       32'd0);
    check("rst_wr_stb",  32'(wr_stb),     32'd0);
    check("rst_wr_cnt",  32'(wr_cnt),     32'd0);
    check("rst_wr_addr", 32'(wr_addr),    32'd0);
    check("rst_wr_data", 32'(wr_data),    32'd0);
    @(negedge clk); reset = 1'b1;
    wait_clk(4);

    // Basic 3-phase write
    write3(8'h42, 8'h12, 8'h80, 1'b1);
    check_reg("reg12", 8'h12, 8'h80);
    check("wr_addr_12", 32'(wr_addr), 32'h12);
    check("wr_data_80", 32'(wr_data), 32'h80);
    check("wr_cnt_1",   32'(wr_cnt),  32'd1);

    // Foreign device ID: never acknowledged, nothing written
    oe_watch = 1'b1;
    write3(8'h60, 8'h12, 8'h55, 1'b0);
    oe_watch = 1'b0;
    check("foreign_id_oe_seen", 32'(oe_seen), 32'd0);
    check_reg("reg12_unchanged", 8'h12, 8'h80);
    check("wr_cnt_still_1", 32'(wr_cnt), 32'd1);

    // Repeated START after sub-address 0x20, then a full write to 0x11
    bus_start();
    send_byte(8'h42, a); check("rs_ack_id1", 32'(a), 32'd1);
    send_byte(8'h20, a); check("rs_ack_sub1", 32'(a), 32'd1);
    bus_start();
    check("rs_busy", 32'(busy), 32'd1);
    send_byte(8'h42, a); check("rs_ack_id2", 32'(a), 32'd1);
    send_byte(8'h11, a); check("rs_ack_sub2", 32'(a), 32'd1);
    expect_write(8'h11, 8'h80);
    send_byte(8'h80, a); check("rs_ack_data", 32'(a), 32'd1);
    bus_stop();
    $display("RS 42/20 Sr 42/11/80 wr_cnt=%0d", wr_cnt);
    check_reg("reg11", 8'h11, 8'h80);
    check_reg("reg20_untouched", 8'h20, 8'h00);
    check("wr_cnt_2", 32'(wr_cnt), 32'd2);

    // Write 0x3A=0x04, set pointer with a 2-phase write, then read it back
    write3(8'h42, 8'h3A, 8'h04, 1'b1);
    bus_start();
    send_byte(8'h42, a); check("ptr_ack_id", 32'(a), 32'd1);
    send_byte(8'h3A, a); check("ptr_ack_sub", 32'(a), 32'd1);
    bus_stop();
    check("wr_cnt_after_2phase", 32'(wr_cnt), 32'd3);
    bus_start();
    send_byte(8'h43, a);
`ifdef SCCB_TARGET_READ_EN
    check("rd_ack_id", 32'(a), 32'd1);
    read_byte(d);
    check("rd_data_3a", 32'(d), 32'h04);
    $display("RD id=43 ack=%b data=%02h", a, d);
`else
    check("rd_id_nack", 32'(a), 32'd0);
    $display("RD id=43 ack=%b", a);
`endif
    bus_stop();
    check("busy_after_read", 32'(busy), 32'd0);
    check_reg("reg3a", 8'h3A, 8'h04);

    // Plain reset pulse clears everything
    @(negedge clk); reset = 1'b0;
    wait_clk(2);
    @(negedge clk); reset = 1'b1;
    model_reset();
    wait_clk(2);
    check_reg("reg12_cleared", 8'h12, 8'h00);
    check_reg("reg3a_cleared", 8'h3A, 8'h00);
    check("wr_cnt_cleared", 32'(wr_cnt), 32'd0);

    // 75-entry init stream: 13=E0, 0x20..0x67 = addr^A5, 69=07, 13=E7
    for (int i = 0; i < 75; i++) begin
      if (i == 0) write3(8'h42, 8'h13, 8'hE0, 1'b1);
      else if (i == 73) write3(8'h42, 8'h69, 8'h07, 1'b1);
      else if (i == 74) write3(8'h42, 8'h13, 8'hE7, 1'b1);
      else begin
        sa = 8'(8'h1F + i);
        write3(8'h42, sa, sa ^ 8'hA5, 1'b1);
      end
    end
    check("init_wr_cnt", 32'(wr_cnt), 32'd75);
    check_reg("init_reg69", 8'h69, 8'h07);
    check_reg("init_reg13", 8'h13, 8'hE7);
    check_reg("init_reg30", 8'h30, 8'h95);
    check_reg("init_reg67", 8'h67, 8'hC2);

    // Reset in the middle of the data byte (after 4 data bits)
    bus_start();
    send_byte(8'h42, a); check("mid_ack_id", 32'(a), 32'd1);
    send_byte(8'h3B, a); check("mid_ack_sub", 32'(a), 32'd1);
    for (int i = 7; i >= 4; i--) send_bit(1'b1);
    check("mid_busy_before", 32'(busy), 32'd1);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    check("mid_rst_busy",   32'(busy),       32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(4);
    @(negedge clk); reset = 1'b1;
    model_reset();
    wait_clk(4);
    $display("RST during data bit 4 busy=%b sda_oe=%b", busy, bus.sda_oe);
    check("mid_wr_cnt", 32'(wr_cnt), 32'd0);
    check_reg("mid_reg3b", 8'h3B, 8'h00);
    write3(8'h42, 8'h3B, 8'h55, 1'b1);
    check_reg("post_rst_reg3b", 8'h3B, 8'h55);
    check("post_rst_wr_cnt", 32'(wr_cnt), 32'd1);

    wait_clk(4);
    check("pending_strobes", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
